// File: rtl/tqvp_crc_engine.sv
// Programmable CRC peripheral for the TinyQV user-peripheral slot.
// Folds one latched byte per 8/BITS_PER_CYCLE busy cycles into a CRC_W-bit remainder.
module tqvp_crc_engine #(
    parameter int          CRC_W          = 32,
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [31:0] POLY_RST       = 32'h04C11DB7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int               CYC      = 8 / BITS_PER_CYCLE;
    localparam logic [2:0]       CNT_LAST = 3'(CYC - 1);
    localparam logic [CRC_W-1:0] ONES     = {CRC_W{1'b1}};

    logic [CRC_W-1:0] r_poly;
    logic [CRC_W-1:0] r_init;
    logic [CRC_W-1:0] r_crc;
    logic             r_refin;
    logic             r_refout;
    logic             r_xorout;
    logic             r_busy;
    logic             r_overrun;
    logic [2:0]       r_cnt;
    logic [7:0]       r_shift;

    logic             w_wr_ctrl;
    logic             w_wr_data;
    logic             w_wr_stat;
    logic             w_wr_poly;
    logic             w_wr_init;
    logic [CRC_W-1:0] w_result;
    logic [7:0]       w_dout;
    logic             w_unused;

    // Fold BITS_PER_CYCLE message bits, taken from the byte's LSB end when reflected.
    function automatic logic [CRC_W-1:0] f_fold(input logic [CRC_W-1:0] crc,
                                                input logic [CRC_W-1:0] poly,
                                                input logic [7:0]       sh,
                                                input logic             refin);
        logic [CRC_W-1:0] c;
        logic             d;
        logic             fb;
        c = crc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            d  = refin ? sh[i] : sh[7-i];
            fb = c[CRC_W-1] ^ d;
            c  = (c << 1) ^ (fb ? poly : '0);
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] f_bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    // Byte-lane write; lanes or bits at or above CRC_W are dropped.
    function automatic logic [CRC_W-1:0] f_wr_byte(input logic [CRC_W-1:0] cur,
                                                   input logic [1:0]       idx,
                                                   input logic [7:0]       b);
        logic [CRC_W-1:0] r;
        r = cur;
        for (int i = 0; i < CRC_W; i++) begin
            if ((i / 8) == int'(idx)) begin
                r[i] = b[i % 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] f_rd_byte(input logic [CRC_W-1:0] v,
                                             input logic [1:0]       idx);
        logic [7:0] b;
        int         bi;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            bi = int'(idx) * 8 + j;
            if (bi < CRC_W) begin
                b[j] = v[bi];
            end
        end
        return b;
    endfunction

    assign w_wr_ctrl = data_write && (address == 4'h0);
    assign w_wr_data = data_write && (address == 4'h1);
    assign w_wr_stat = data_write && (address == 4'h2);
    assign w_wr_poly = data_write && (address[3:2] == 2'b01);
    assign w_wr_init = data_write && (address[3:2] == 2'b10);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_poly    <= POLY_RST[CRC_W-1:0];
            r_init    <= ONES;
            r_crc     <= ONES;
            r_refin   <= 1'b1;
            r_refout  <= 1'b1;
            r_xorout  <= 1'b1;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_busy) begin
                r_crc <= f_fold(r_crc, r_poly, r_shift, r_refin);
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == CNT_LAST) begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                end
            end

            // Clears come first so that a same-cycle overrun set wins.
            if (w_wr_stat) begin
                r_overrun <= 1'b0;
            end

            if (w_wr_ctrl) begin
                if (data_in[0]) begin
                    r_refin   <= data_in[1];
                    r_refout  <= data_in[2];
                    r_xorout  <= data_in[3];
                    r_crc     <= r_init;
                    r_busy    <= 1'b0;
                    r_cnt     <= '0;
                    r_overrun <= 1'b0;
                end else if (!r_busy) begin
                    r_refin  <= data_in[1];
                    r_refout <= data_in[2];
                    r_xorout <= data_in[3];
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_wr_data) begin
                if (!r_busy) begin
                    r_busy <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_wr_poly) begin
                if (!r_busy) begin
                    r_poly <= f_wr_byte(r_poly, address[1:0], data_in);
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_wr_init) begin
                if (!r_busy) begin
                    r_init <= f_wr_byte(r_init, address[1:0], data_in);
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // Message byte shifter: pure datapath, qualified by r_busy.
    always_ff @(posedge clk) begin
        if (w_wr_data && !r_busy) begin
            r_shift <= data_in;
        end else if (r_busy) begin
            r_shift <= r_refin ? (r_shift >> BITS_PER_CYCLE) : (r_shift << BITS_PER_CYCLE);
        end
    end

    assign w_result = (r_refout ? f_bitrev(r_crc) : r_crc) ^ (r_xorout ? ONES : '0);

    always_comb begin
        w_dout = '0;
        case (address[3:2])
            2'b00: begin
                if (address[1:0] == 2'b10) begin
                    w_dout = {3'b000, r_xorout, r_refout, r_refin, r_overrun, r_busy};
                end
            end
            2'b01:   w_dout = f_rd_byte(r_poly, address[1:0]);
            2'b10:   w_dout = f_rd_byte(r_init, address[1:0]);
            default: w_dout = f_rd_byte(w_result, address[1:0]);
        endcase
    end

    assign data_out = w_dout;
    assign uo_out   = {6'b000000, r_overrun, r_busy};
    assign w_unused = ^ui_in;

endmodule

// File: tb/tb_tqvp_crc_engine.sv
// Randomised self-checking bench for tqvp_crc_engine: a CRC-32/1-bit unit and a CRC-16/8-bit unit
// compared against a byte-oriented CRC reference model plus published check values.
module tb_tqvp_crc_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [3:0] addr [2];
    logic       we   [2];
    logic [7:0] din  [2];
    logic [7:0] dout [2];
    logic [7:0] uo   [2];

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] msg [32];
    int         msg_len;

    always #5 clk = ~clk;

    tqvp_crc_engine u_crc32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo[0]),
        .address    (addr[0]),
        .data_write (we[0]),
        .data_in    (din[0]),
        .data_out   (dout[0])
    );

    tqvp_crc_engine #(.CRC_W(16), .BITS_PER_CYCLE(8)) u_crc16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo[1]),
        .address    (addr[1]),
        .data_write (we[1]),
        .data_in    (din[1]),
        .data_out   (dout[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned rev(input longint unsigned v, input int n);
        longint unsigned r;
        r = 0;
        for (int i = 0; i < n; i++) begin
            if (((v >> i) & 64'd1) != 0) r |= (64'd1 << (n - 1 - i));
        end
        return r;
    endfunction

    // Classic byte-at-a-time CRC over msg[0..msg_len-1].
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly, input logic [31:0] init,
                                            input bit ri, input bit ro, input bit xo);
        longint unsigned mask, c, p, b;
        mask = (64'd1 << w) - 64'd1;
        c    = longint'(init) & mask;
        p    = longint'(poly) & mask;
        for (int i = 0; i < msg_len; i++) begin
            b = longint'(msg[i]);
            if (ri) b = rev(b, 8);
            c ^= b << (w - 8);
            for (int k = 0; k < 8; k++) begin
                if (((c >> (w - 1)) & 64'd1) != 0) c = ((c << 1) ^ p) & mask;
                else                               c = (c << 1) & mask;
            end
        end
        if (ro) c = rev(c, w);
        if (xo) c ^= mask;
        return c[31:0];
    endfunction

    task automatic wr(input int u, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        addr[u] = a;
        din[u]  = d;
        we[u]   = 1'b1;
        @(negedge clk);
        we[u]   = 1'b0;
    endtask

    task automatic rd(input int u, input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        addr[u] = a;
        #1;
        d = dout[u];
    endtask

    task automatic rd32(input int u, input logic [3:0] base, output logic [31:0] v);
        logic [7:0] b;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            rd(u, 4'(int'(base) + k), b);
            v[k*8 +: 8] = b;
        end
    endtask

    task automatic wait_idle(input int u, output int n);
        n = 0;
        while (uo[u][0] && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send(input int u, input int cyc, input bit b2b);
        int n;
        for (int i = 0; i < msg_len; i++) begin
            wr(u, 4'h1, msg[i]);
            if (b2b) begin
                repeat (cyc - 1) @(negedge clk);
            end else begin
                wait_idle(u, n);
                chk("busy_cycles", n, cyc);
            end
        end
        wait_idle(u, n);
    endtask

    task automatic load_check_str();
        msg_len = 9;
        for (int i = 0; i < 9; i++) msg[i] = 8'(8'h31 + i);
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        int          u, w, n;
        logic [31:0] poly, init, mask;
        bit          ri, ro, xo, b2b;

        ui_in = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; we[i] = 1'b0; din[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        rd(0, 4'h2, b);   chk("rst_status", b, 8'h1C);
        chk("rst_uo", uo[0], 8'h00);
        rd32(0, 4'h4, v); chk("rst_poly", v, 32'h04C11DB7);
        rd32(0, 4'h8, v); chk("rst_init", v, 32'hFFFFFFFF);
        rd32(0, 4'hC, v); chk("rst_result", v, 32'h00000000);
        rd32(1, 4'h4, v); chk("rst_poly16", v, 32'h00001DB7);
        rd32(1, 4'h8, v); chk("rst_init16", v, 32'h0000FFFF);

        // CRC-32 with reset configuration
        load_check_str();
        send(0, 8, 1'b0);
        rd32(0, 4'hC, v); chk("crc32_check", v, 32'hCBF43926);

        // CRC-32/MPEG-2
        wr(0, 4'h0, 8'h01);
        send(0, 8, 1'b0);
        rd32(0, 4'hC, v); chk("mpeg2_check", v, 32'h0376E6E7);

        // CRC-16/CCITT-FALSE on the 16-bit, byte-per-cycle unit
        wr(1, 4'h4, 8'h21); wr(1, 4'h5, 8'h10); wr(1, 4'h6, 8'hAB);
        rd(1, 4'h6, b);    chk("poly16_hi_ignored", b, 8'h00);
        wr(1, 4'h8, 8'hFF); wr(1, 4'h9, 8'hFF);
        wr(1, 4'h0, 8'h01);
        send(1, 1, 1'b0);
        rd32(1, 4'hC, v);  chk("ccitt_check", v, 32'h000029B1);

        // Overrun from a DATA write mid-byte
        wr(0, 4'h0, 8'h0F);
        msg_len = 1; msg[0] = 8'($urandom);
        wr(0, 4'h1, msg[0]);
        @(negedge clk); @(negedge clk);
        wr(0, 4'h1, 8'($urandom));
        rd(0, 4'h2, b);   chk("ovr_status", b, 8'h1F);
        chk("ovr_uo", uo[0], 8'h03);
        wait_idle(0, n);
        rd32(0, 4'hC, v); chk("ovr_result", v, ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 1, 1, 1));
        wr(0, 4'h2, 8'h00);
        rd(0, 4'h2, b);   chk("ovr_cleared", b, 8'h1C);
        chk("ovr_uo_cleared", uo[0], 8'h00);

        // CTRL clear aborts a byte; CTRL without clear while busy is an overrun
        wr(0, 4'h1, 8'($urandom));
        @(negedge clk);
        wr(0, 4'h0, 8'h0F);
        chk("abort_busy", uo[0], 8'h00);
        rd32(0, 4'hC, v); chk("abort_result", v, 32'h00000000);
        msg[0] = 8'($urandom);
        wr(0, 4'h1, msg[0]);
        wr(0, 4'h0, 8'h0E);
        rd(0, 4'h2, b);   chk("ctrl_busy_status", b, 8'h1F);
        wait_idle(0, n);
        rd32(0, 4'hC, v); chk("ctrl_busy_result", v, ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 1, 1, 1));
        wr(0, 4'h2, 8'h00);

        // Reset mid-byte with a modified polynomial
        wr(0, 4'h4, 8'h00);
        wr(0, 4'h1, 8'h5A);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd32(0, 4'h4, v); chk("midrst_poly", v, 32'h04C11DB7);
        chk("midrst_busy", uo[0], 8'h00);
        rd32(0, 4'hC, v); chk("midrst_result", v, 32'h00000000);
        rd(0, 4'h2, b);   chk("midrst_status", b, 8'h1C);

        // Randomised configurations and messages on both units
        for (int r = 0; r < 24; r++) begin
            u    = r % 2;
            w    = (u == 0) ? 32 : 16;
            mask = (u == 0) ? 32'hFFFFFFFF : 32'h0000FFFF;
            poly = $urandom | 32'h1;
            init = $urandom;
            ri   = 1'($urandom); ro = 1'($urandom); xo = 1'($urandom);
            b2b  = (r % 4) >= 2;
            for (int k = 0; k < 4; k++) wr(u, 4'(4 + k), poly[k*8 +: 8]);
            for (int k = 0; k < 4; k++) wr(u, 4'(8 + k), init[k*8 +: 8]);
            wr(u, 4'h0, {4'b0000, xo, ro, ri, 1'b1});
            rd32(u, 4'h4, v); chk("rnd_poly", v, poly & mask);
            msg_len = 0;
            rd32(u, 4'hC, v); chk("rnd_empty", v, ref_crc(w, poly, init, ri, ro, xo));
            msg_len = $urandom_range(1, 12);
            for (int i = 0; i < msg_len; i++) msg[i] = 8'($urandom);
            send(u, (u == 0) ? 8 : 1, b2b);
            rd32(u, 4'hC, v); chk("rnd_result", v, ref_crc(w, poly, init, ri, ro, xo));
            rd(u, 4'h2, b);   chk("rnd_status", b, {3'b000, xo, ro, ri, 2'b00});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tqvp_crc_engine.md
Name: tqvp_crc_engine

Overview:
Parametrised, programmable CRC peripheral for the TinyQV user-peripheral slot. Polynomial, initial value, input/output reflection and final XOR are software-configurable. Bytes are processed sequentially at BITS_PER_CYCLE bits per clock, with a busy/overrun handshake. Default reset configuration computes standard CRC-32 (IEEE, reflected), so software needs no setup for the common case.

Parameters:
CRC_W, 32, CRC width in bits; legal values 8..32.
BITS_PER_CYCLE, 1, bits folded per clock; legal values 1, 2, 4, 8. Busy time per byte = 8/BITS_PER_CYCLE cycles.
POLY_RST, 32'h04C11DB7, reset polynomial (normal form), truncated to CRC_W.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
ui_in  input  8  unused
uo_out  output  8  [0]=busy, [1]=overrun, [7:2]=0
address  input  4  register address
data_write  input  1  write strobe, one cycle per write
data_in  input  8  write data, valid with data_write
data_out  output  8  combinational read data for address

Behaviour:
- Address map:
  - 0x0 CTRL (W): [0]=clear, [1]=refin, [2]=refout, [3]=xorout_en.
  - 0x1 DATA (W): push one byte.
  - 0x2 STATUS (R): [0]=busy, [1]=overrun, [2]=refin, [3]=refout, [4]=xorout_en. A write of any value clears overrun.
  - 0x4-0x7 POLY byte0..3 (R/W).
  - 0x8-0xB INIT byte0..3 (R/W).
  - 0xC-0xF RESULT byte0..3 (R; writes ignored).
  - Other addresses read 0. POLY/INIT/RESULT bits at or above CRC_W read 0 and ignore writes.
- Reset (rst_n low at posedge):
  - POLY=POLY_RST, INIT=all-ones, crc=all-ones.
  - refin=1, refout=1, xorout_en=1.
  - busy=0, overrun=0, bit counter=0, uo_out=0.
  - Reset mid-byte aborts the byte; no partial update survives.
- CTRL write, not busy: latch bits [3:1]. If [0]=1, also load crc<=INIT (INIT as currently held).
- CTRL write while busy:
  - If [0]=1: abort the byte, busy<=0, counter<=0, latch config, crc<=INIT.
  - If [0]=0: ignored, overrun<=1.
- DATA write, not busy:
  - Latch byte into shift reg; busy=1 from the next cycle.
  - Each busy cycle folds BITS_PER_CYCLE bits, LSB-first if refin, else MSB-first.
  - Per bit: fb=crc[CRC_W-1]^d; crc=(crc<<1)^(fb?POLY:0), masked to CRC_W.
  - Busy lasts exactly 8/BITS_PER_CYCLE cycles. crc holds its final value in the cycle busy drops.
- DATA/POLY/INIT write while busy: ignored, overrun<=1 (sticky until STATUS write, CTRL clear, or reset).
- STATUS write in the same cycle as an overrun-causing write: set wins.
- RESULT (combinational from crc):
  - r = refout ? bit-reverse over CRC_W : crc.
  - If xorout_en, r ^= all-ones(CRC_W).
  - RESULT read while busy returns the intermediate value; software must poll busy.
- Back-to-back: a DATA write is accepted in the first cycle busy reads 0.
- Throughput: 1 byte per (8/BITS_PER_CYCLE + 1) cycles worst case, counting the write cycle.

Test Plan:
1. Reset, no config; write "123456789" to DATA, polling busy between bytes -> RESULT = 0xCBF43926; busy high exactly 8 cycles per byte (BITS_PER_CYCLE=1).
2. CTRL=0x01 (refin=0, refout=0, xorout_en=0, clear), INIT=0xFFFFFFFF, "123456789" -> RESULT = 0x0376E6E7 (CRC-32/MPEG-2).
3. CRC_W=16, BITS_PER_CYCLE=8 instance: POLY=0x1021, INIT=0xFFFF, CTRL=0x01, "123456789" -> RESULT bytes 0xB1, 0x29, 0x00, 0x00. Busy high 1 cycle per byte.
4. DATA write, then a second DATA write 3 cycles later -> second byte dropped, STATUS[1]=1, uo_out[1]=1, RESULT equals the single-byte CRC. STATUS write -> overrun=0.
5. CTRL=0x0F mid-byte -> busy=0 next cycle, RESULT = ~bitrev(INIT) = 0x00000000 with defaults. CTRL=0x0E mid-byte -> ignored, overrun=1.
6. rst_n low for one cycle mid-byte with POLY modified -> POLY reads 0x04C11DB7, busy=0, RESULT=0x00000000, STATUS=0x1C.
